// File: rtl/trp_seq_ctrl.sv
// Job sequencer for the trp_fifo transposer: init, fill NROW rows, drain NROW vectors
// through a 2-entry store that absorbs the buffer's fixed 1-cycle read latency.
//
//   state   | meaning
//   S_IDLE  | waiting for start; ff_mode latched on a legal start
//   S_INIT  | one-cycle ffinit, counters cleared
//   S_FILL  | accepting rows on s_valid/s_ready, one ffwreq per row
//   S_DRAIN | issuing ffrreq, streaming vectors out on m_valid/m_ready
module trp_seq_ctrl #(
  parameter int BUFFD = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [1:0]         ff_mode,
  output logic               ffinit,
  output logic               ffwreq,
  output logic               ffrreq,
  input  logic [BUFFD*8-1:0] ffrdata,
  input  logic               ffrvld,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BUFFD*8-1:0] m_data,
  output logic               m_last
);

  localparam int CW = $clog2(BUFFD) + 1;
  localparam int DW = BUFFD * 8;
  localparam logic [CW-1:0] NR8  = CW'(BUFFD);
  localparam logic [CW-1:0] NR32 = CW'(BUFFD / 4);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [1:0] MODE_BIT8  = 2'b01;
  localparam logic [1:0] MODE_BIT32 = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FILL, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [CW-1:0]   ocnt_q, ocnt_d;
  logic            inflt_q;
  logic            drop_q, drop_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [DW-1:0]   ent0_q, ent0_d;
  logic [DW-1:0]   ent1_q, ent1_d;

  logic [CW-1:0]   nrow;
  logic            pop;
  logic            push;
  logic            rd_c;
  logic [2:0]      pend;

  assign nrow    = (mode_q == MODE_BIT8) ? NR8 : NR32;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = ent0_q;
  assign m_last  = m_valid && (ocnt_q == nrow - ONE);
  assign pop     = m_valid & m_ready;
  // A read that lands the cycle after an abort belongs to the cancelled job.
  assign push    = ffrvld & ~drop_q;

  assign busy    = (state_q != S_IDLE);
  assign ffinit  = (state_q == S_INIT);
  assign s_ready = (state_q == S_FILL);
  assign ffwreq  = s_valid & s_ready;
  assign ff_mode = mode_q;
  assign done    = done_q;
  assign err     = err_q;

  // Reads in flight plus stored entries, net of this cycle's pop, must leave room.
  assign pend    = {2'b00, inflt_q} + {1'b0, cnt_q} - {2'b00, pop};
  assign rd_c    = (state_q == S_DRAIN) && (rcnt_q < nrow) && (pend < 3'd2);
  assign ffrreq  = rd_c;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ocnt_d  = ocnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (mode_in == MODE_BIT8 || mode_in == MODE_BIT32) begin
            mode_d  = mode_in;
            state_d = S_INIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_INIT: begin
        wcnt_d  = '0;
        rcnt_d  = '0;
        ocnt_d  = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        if (ffwreq) begin
          wcnt_d = wcnt_q + ONE;
          if (wcnt_q == nrow - ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rd_c) rcnt_d = rcnt_q + ONE;
        if (pop) begin
          ocnt_d = ocnt_q + ONE;
          if (m_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = ffrdata;
        else               ent1_d = ffrdata;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = ffrdata;
        end else begin
          ent0_d = ent1_q;
          ent1_d = ffrdata;
        end
      end
      default: ;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      drop_d  = 1'b1;
      cnt_d   = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      ocnt_q  <= '0;
      inflt_q <= 1'b0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      ocnt_q  <= ocnt_d;
      inflt_q <= rd_c;
      drop_q  <= drop_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
    end
  end

endmodule

// File: tb/tb_trp_seq_ctrl.sv
// Bench for trp_seq_ctrl (BUFFD=8) with a behavioural trp_fifo and a queue scoreboard.
module tb_trp_seq_ctrl;
  localparam int BUFFD = 8;
  localparam int DW    = BUFFD * 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    mode_in;
  logic          abort;
  logic          busy, done, err;
  logic          s_valid, s_ready;
  logic [1:0]    ff_mode;
  logic          ffinit, ffwreq, ffrreq;
  logic [DW-1:0] ffrdata;
  logic          ffrvld;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic [DW-1:0] s_data;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int rdy_mode = 0;

  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  trp_seq_ctrl #(.BUFFD(BUFFD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_in(mode_in), .abort(abort),
    .busy(busy), .done(done), .err(err), .s_valid(s_valid), .s_ready(s_ready),
    .ff_mode(ff_mode), .ffinit(ffinit), .ffwreq(ffwreq), .ffrreq(ffrreq),
    .ffrdata(ffrdata), .ffrvld(ffrvld), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  // Behavioural buffer: pointers survive reset so a missing ffinit corrupts data.
  logic [DW-1:0] rows [BUFFD];
  int wptr = 0;
  int rptr = 0;

  function automatic logic [DW-1:0] tvec(int k, logic [1:0] md);
    logic [DW-1:0] v;
    logic [DW-1:0] r;
    v = '0;
    for (int i = 0; i < BUFFD; i++) begin
      if (md == 2'b01) begin
        r = rows[i];
        v[i*8 +: 8] = r[k*8 +: 8];
      end else begin
        r = rows[i/4];
        v[i*8 +: 8] = r[(k*4 + i%4)*8 +: 8];
      end
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ffrvld  <= 1'b0;
      ffrdata <= '0;
    end else begin
      if (ffinit) begin
        wptr <= 0;
        rptr <= 0;
      end
      if (ffwreq) begin
        rows[wptr % BUFFD] <= s_data;
        wptr <= wptr + 1;
      end
      ffrvld <= ffrreq;
      if (ffrreq) begin
        ffrdata <= tvec(rptr % BUFFD, ff_mode);
        rptr <= rptr + 1;
      end
    end
  end

  task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // m_ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = never ready
  initial begin
    int ph = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: begin
          m_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability and done timing.
  logic          stall_prev = 1'b0;
  logic          expect_done = 1'b0;
  logic [DW-1:0] hold_data;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev  = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (expect_done) begin
        check("done_after_last", DW'(done), DW'(1));
        expect_done = 1'b0;
      end
      if (stall_prev) begin
        check("hold_valid", DW'(m_valid), DW'(1));
        check("hold_data", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_vector");
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("m_data", m_data, e[DW-1:0]);
          check("m_last", DW'(m_last), DW'(e[DW]));
          if (m_last) expect_done = 1'b1;
        end
      end
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
    end
  end

  function automatic logic [DW-1:0] mkrow(int r, logic [7:0] key);
    logic [DW-1:0] v;
    for (int c = 0; c < BUFFD; c++) v[c*8 +: 8] = 8'(r*8 + c) ^ key;
    return v;
  endfunction

  // BIT8: vector k byte i = row i byte k
  task automatic push_bit8(logic [7:0] key);
    for (int k = 0; k < BUFFD; k++) begin
      logic [DW-1:0] v;
      for (int i = 0; i < BUFFD; i++) v[i*8 +: 8] = 8'(i*8 + k) ^ key;
      exp_q.push_back({(k == BUFFD-1), v});
    end
  endtask

  // BIT32: vector k byte i = row (i/4) byte (k*4 + i%4)
  task automatic push_bit32(logic [7:0] key);
    for (int k = 0; k < BUFFD/4; k++) begin
      logic [DW-1:0] v;
      for (int i = 0; i < BUFFD; i++) v[i*8 +: 8] = 8'((i/4)*8 + k*4 + i%4) ^ key;
      exp_q.push_back({(k == BUFFD/4-1), v});
    end
  endtask

  task automatic start_job(logic [1:0] md);
    start   = 1'b1;
    mode_in = md;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_rows(int n, logic [7:0] key);
    for (int r = 0; r < n; r++) begin
      int t;
      s_data  = mkrow(r, key);
      s_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) fail_now("s_ready_timeout");
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(int exp_cnt);
    int t;
    t = 0;
    while (done_cnt < exp_cnt && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_count", DW'(done_cnt), DW'(exp_cnt));
    check("sb_empty", DW'(exp_q.size()), DW'(0));
    check("busy_after_done", DW'(busy), DW'(0));
  endtask

  task automatic check_all_zero(string nm);
    check(nm, DW'({busy, done, err, s_ready, ffinit, ffwreq, ffrreq, m_valid, m_last, ff_mode}), '0);
    check({nm, "_mdata"}, m_data, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mode_in = 2'b00;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_release");
    @(posedge clk); #1;

    // Job 1: BIT8, always ready
    rdy_mode = 0;
    push_bit8(8'h00);
    start_job(2'b01);
    check("ffinit_pulse", DW'(ffinit), DW'(1));
    check("ff_mode_bit8", DW'(ff_mode), DW'(2'b01));
    send_rows(8, 8'h00);
    wait_done(1);

    // Illegal mode
    start   = 1'b1;
    mode_in = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", DW'(err), DW'(1));
    check("err_busy", DW'(busy), DW'(0));
    @(posedge clk); #1;
    check("err_single", DW'(err), DW'(0));
    check("err_mode_kept", DW'(ff_mode), DW'(2'b01));

    // Job 2: BIT8 with stalled drain and a start while busy
    rdy_mode = 1;
    push_bit8(8'h5A);
    start_job(2'b01);
    start   = 1'b1;
    mode_in = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    check("ff_mode_held", DW'(ff_mode), DW'(2'b01));
    check("busy_during_job", DW'(busy), DW'(1));
    send_rows(8, 8'h5A);
    wait_done(2);

    // Job 3: BIT32, two rows then s_ready drops
    rdy_mode = 0;
    push_bit32(8'h00);
    start_job(2'b10);
    check("ff_mode_bit32", DW'(ff_mode), DW'(2'b10));
    send_rows(2, 8'h00);
    check("s_ready_after_fill", DW'(s_ready), DW'(0));
    wait_done(3);

    // Abort the cycle after the first read request
    rdy_mode = 2;
    start_job(2'b01);
    send_rows(8, 8'h33);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!ffrreq && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!ffrreq) fail_now("ffrreq_timeout");
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    rdy_mode = 0;
    check("abort_busy", DW'(busy), DW'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_mvalid", DW'(m_valid), DW'(0));
    end
    check("abort_no_done", DW'(done_cnt), DW'(3));

    // Job after abort, stalled drain
    rdy_mode = 1;
    @(posedge clk); #1;
    push_bit8(8'hC3);
    start_job(2'b01);
    send_rows(8, 8'hC3);
    wait_done(4);

    // Reset in the middle of FILL, then a BIT32 job
    rdy_mode = 0;
    start_job(2'b01);
    send_rows(3, 8'h11);
    reset_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    push_bit32(8'h77);
    start_job(2'b10);
    check("ffinit_after_reset", DW'(ffinit), DW'(1));
    send_rows(2, 8'h77);
    wait_done(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
